// File: rtl/axi_rd_arb_pkg.sv
// Shared constants and helpers for the AXI read arbiter.
// Latency: none (package only).
// Backpressure: not applicable.
package axi_rd_arb_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_arb_route_fifo.sv
// Route FIFO holding the requester index of every in-flight AR, oldest at head.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when count_o == DEPTH.
module rr_route_fifo
  import axi_rd_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic [clog2(DEPTH):0]  count_o,
  output logic                   empty_o
);

  localparam int PTR_W = clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Pointers wrap naturally; count only moves when exactly one of push/pop fires.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // State and storage registers, all cleared by reset so in-flight routes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin AR arbiter for NUM_REQ requesters onto one single-beat AXI read port, R beats routed back in order.
// Latency: AR 1 cycle (registered slot), R 0 cycles (combinational steer by route FIFO head).
// Backpressure: AR accepted only if the slot frees this cycle and fewer than MAX_OUTSTANDING are in flight; R stalls on the head requester's rready.
// Option: define AXI_RD_ARB_STRICT_PRIO_EN for fixed priority (lowest index wins).
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_axi_arvalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_axi_araddr,
  output logic [NUM_REQ-1:0]            s_axi_arready,
  output logic [NUM_REQ-1:0]            s_axi_rvalid,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [NUM_REQ-1:0]            s_axi_rlast,
  input  logic [NUM_REQ-1:0]            s_axi_rready,
  output logic                          m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  input  logic                          m_axi_arready,
  input  logic                          m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  output logic                          m_axi_rready
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_OUTSTANDING) + 1;

  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  slot_free, full, accept, pop, empty;
  logic [IDX_W-1:0]      head;
  logic [CNT_W-1:0]      count;

`ifdef AXI_RD_ARB_STRICT_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index is the last one written.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (s_axi_arvalid[i]) begin
        grant_idx = IDX_W'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;

  // Round-robin: first valid requester found walking up from last_grant+1 with wrap.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + 1 + i) % NUM_REQ);
      if (!grant_vld && s_axi_arvalid[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

  // last_grant moves only on accept so a stalled winner keeps its turn.
  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant_idx;
  end

  // Reset to the top index so requester 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
`endif

  // Full uses the registered count only; a same-cycle pop does not open a slot.
  assign slot_free = ~arvalid_q | m_axi_arready;
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign accept    = grant_vld & slot_free & ~full;

  // Steer the accept onto the winner's arready.
  always_comb begin
    s_axi_arready = '0;
    if (accept) s_axi_arready[grant_idx] = 1'b1;
  end

  // Output slot: load on accept, otherwise drain when downstream takes it.
  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    if (accept) begin
      arvalid_d = 1'b1;
      araddr_d  = s_axi_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end else if (m_axi_arready) begin
      arvalid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
    end
  end

  rr_route_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_dat_i (grant_idx),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .empty_o    (empty)
  );

  // rready must not look at rvalid: downstream gates its rvalid with our rready.
  assign m_axi_rready = ~empty & s_axi_rready[head];
  assign pop          = m_axi_rvalid & m_axi_rready;

  // Beat is shown only to the head requester; nothing is shown with no route.
  always_comb begin
    s_axi_rvalid = '0;
    if (!empty && m_axi_rvalid) s_axi_rvalid[head] = 1'b1;
  end

  assign s_axi_rlast   = s_axi_rvalid;
  assign s_axi_rdata   = m_axi_rdata;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = AXI_LEN_SINGLE;
  assign m_axi_arsize  = 3'(clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb: directed vector table, hand sequences, random vs queue model.
// Latency: checks combinational outputs 1 time unit after inputs change at the falling edge.
// Backpressure: exercised through m_axi_arready, s_axi_rready and the outstanding limit.
module tb_axi_rd_arb;

  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int MO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_axi_arvalid;
  logic [N*AW-1:0] s_axi_araddr;
  logic [N-1:0]    s_axi_arready;
  logic [N-1:0]    s_axi_rvalid;
  logic [DW-1:0]   s_axi_rdata;
  logic [N-1:0]    s_axi_rlast;
  logic [N-1:0]    s_axi_rready;
  logic            m_axi_arvalid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arready;
  logic            m_axi_rvalid;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rready;

  always #5 clk = ~clk;

  axi_rd_arb #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr(s_axi_araddr), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .s_axi_rready(s_axi_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rready(m_axi_rready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] av, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3, input logic mar,
                       input logic mrv, input logic [DW-1:0] rd, input logic [N-1:0] rr);
    s_axi_arvalid = av;
    s_axi_araddr  = {a3, a2, a1, a0};
    m_axi_arready = mar;
    m_axi_rvalid  = mrv;
    m_axi_rdata   = rd;
    s_axi_rready  = rr;
  endtask

  // Reference model: slot contents, last winner, and a queue of in-flight requester ids.
  bit            mslot_v;
  logic [AW-1:0] mslot_a;
  int            mlast;
  int            rq[$];

  task automatic model_reset();
    mslot_v = 1'b0;
    mslot_a = '0;
    mlast   = N - 1;
    rq.delete();
  endtask

  // Winner = valid requester at the smallest positive distance after the last winner.
  function automatic int pick(input logic [N-1:0] av, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (av[k]) begin
`ifdef AXI_RD_ARB_STRICT_PRIO_EN
        d = k;
`else
        d = (k - last - 1 + 2 * N) % N;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_cycle();
    bit           free, full, acc, exp_mrr;
    int           g;
    logic [N-1:0] exp_ar, exp_rv;
    free    = !mslot_v || m_axi_arready;
    full    = (rq.size() >= MO);
    g       = pick(s_axi_arvalid, mlast);
    acc     = (g >= 0) && free && !full;
    exp_ar  = acc ? (N'(1) << g) : '0;
    exp_mrr = (rq.size() > 0) && s_axi_rready[rq[0]];
    exp_rv  = ((rq.size() > 0) && m_axi_rvalid) ? (N'(1) << rq[0]) : '0;
    chk("rnd_arready", s_axi_arready, exp_ar);
    chk("rnd_rvalid", s_axi_rvalid, exp_rv);
    chk("rnd_rlast", s_axi_rlast, exp_rv);
    chk("rnd_m_rready", m_axi_rready, exp_mrr);
    chk("rnd_m_arvalid", m_axi_arvalid, mslot_v);
    chk("rnd_m_araddr", m_axi_araddr, mslot_a);
    chk("rnd_rdata", s_axi_rdata, m_axi_rdata);
    if (m_axi_rvalid && exp_mrr) void'(rq.pop_front());
    if (acc) begin
      mslot_v = 1'b1;
      mslot_a = s_axi_araddr[g*AW +: AW];
      rq.push_back(g);
      mlast = g;
    end else if (m_axi_arready) begin
      mslot_v = 1'b0;
    end
  endtask

  typedef struct {
    logic [N-1:0]  av;
    logic [AW-1:0] addr;
    logic          mar;
    logic          mrv;
    logic [DW-1:0] rd;
    logic [N-1:0]  rr;
    logic [N-1:0]  e_ar;
    logic          e_mav;
    logic [AW-1:0] e_maddr;
    logic [N-1:0]  e_rv;
    logic          e_mrr;
  } vec_t;

  vec_t tbl[13];

  task automatic do_reset();
    @(negedge clk);
    drive('0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '1);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive('0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    #12;
    chk("reset_m_arvalid", m_axi_arvalid, 1'b0);
    chk("reset_m_araddr", m_axi_araddr, '0);
    chk("reset_arready", s_axi_arready, '0);
    chk("reset_rvalid", s_axi_rvalid, '0);
    chk("reset_rlast", s_axi_rlast, '0);
    chk("reset_m_rready", m_axi_rready, 1'b0);
    chk("reset_count", dut.count, '0);
    chk("const_arlen", m_axi_arlen, 8'd0);
    chk("const_arsize", m_axi_arsize, 3'd2);
    chk("const_arburst", m_axi_arburst, 2'b01);
    @(negedge clk);
    rst = 1'b0;

`ifndef AXI_RD_ARB_STRICT_PRIO_EN
    //         av       addr      mar   mrv   rd            rr       e_ar     e_mav e_maddr   e_rv     e_mrr
    tbl[0]  = '{4'b0100, 48'h1000, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0100, 1'b0, 48'h0,    4'b0000, 1'b0};
    tbl[1]  = '{4'b0000, 48'h0,    1'b1, 1'b1, 32'hDEADBEEF, 4'b1111, 4'b0000, 1'b1, 48'h1000, 4'b0100, 1'b1};
    tbl[2]  = '{4'b0000, 48'h0,    1'b0, 1'b1, 32'h55,       4'b1111, 4'b0000, 1'b0, 48'h1000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0010, 48'hA0,   1'b1, 1'b0, 32'h0,        4'b1111, 4'b0010, 1'b0, 48'h1000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1000, 48'hB0,   1'b1, 1'b0, 32'h0,        4'b1111, 4'b1000, 1'b1, 48'hA0,   4'b0000, 1'b1};
    tbl[5]  = '{4'b0001, 48'hC0,   1'b1, 1'b1, 32'hA,        4'b1111, 4'b0001, 1'b1, 48'hB0,   4'b0010, 1'b1};
    tbl[6]  = '{4'b0000, 48'h0,    1'b1, 1'b1, 32'hB,        4'b1111, 4'b0000, 1'b1, 48'hC0,   4'b1000, 1'b1};
    tbl[7]  = '{4'b0000, 48'h0,    1'b1, 1'b1, 32'hC,        4'b1110, 4'b0000, 1'b0, 48'hC0,   4'b0001, 1'b0};
    tbl[8]  = '{4'b0000, 48'h0,    1'b1, 1'b1, 32'hC,        4'b1111, 4'b0000, 1'b0, 48'hC0,   4'b0001, 1'b1};
    tbl[9]  = '{4'b1111, 48'h2000, 1'b0, 1'b0, 32'h0,        4'b1111, 4'b0010, 1'b0, 48'hC0,   4'b0000, 1'b0};
    tbl[10] = '{4'b1111, 48'h2000, 1'b0, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b1, 48'h2000, 4'b0000, 1'b1};
    tbl[11] = '{4'b1111, 48'h3000, 1'b1, 1'b0, 32'h0,        4'b1111, 4'b0100, 1'b1, 48'h2000, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 48'h0,    1'b0, 1'b0, 32'h0,        4'b1111, 4'b0000, 1'b1, 48'h3000, 4'b0000, 1'b1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].addr, tbl[i].addr, tbl[i].addr, tbl[i].addr,
            tbl[i].mar, tbl[i].mrv, tbl[i].rd, tbl[i].rr);
      #1;
      chk($sformatf("vec%0d_arready", i), s_axi_arready, tbl[i].e_ar);
      chk($sformatf("vec%0d_m_arvalid", i), m_axi_arvalid, tbl[i].e_mav);
      chk($sformatf("vec%0d_m_araddr", i), m_axi_araddr, tbl[i].e_maddr);
      chk($sformatf("vec%0d_rvalid", i), s_axi_rvalid, tbl[i].e_rv);
      chk($sformatf("vec%0d_rlast", i), s_axi_rlast, tbl[i].e_rv);
      chk($sformatf("vec%0d_m_rready", i), m_axi_rready, tbl[i].e_mrr);
      chk($sformatf("vec%0d_rdata", i), s_axi_rdata, tbl[i].rd);
    end

    // Reset with two routes in flight and the slot loaded: state clears immediately.
    @(negedge clk);
    drive('0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_arvalid", m_axi_arvalid, 1'b0);
    chk("midrst_count", dut.count, '0);
    chk("midrst_m_rready", m_axi_rready, 1'b0);
    chk("midrst_m_araddr", m_axi_araddr, '0);
    @(negedge clk);
    rst = 1'b0;

    // Fairness from reset, then fill to the outstanding limit with no R traffic.
    for (int c = 0; c < MO; c++) begin
      @(negedge clk);
      drive(4'b1111, 48'h100, 48'h200, 48'h300, 48'h400, 1'b1, 1'b0, '0, '1);
      #1;
      chk($sformatf("fair_grant%0d", c), s_axi_arready, N'(1) << (c % N));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(4'b1111, 48'h100, 48'h200, 48'h300, 48'h400, 1'b1, 1'b0, '0, '1);
      #1;
      chk("limit_full_arready", s_axi_arready, '0);
    end
    @(negedge clk);
    drive(4'b1111, 48'h100, 48'h200, 48'h300, 48'h400, 1'b1, 1'b1, 32'h77, '1);
    #1;
    chk("limit_pop_arready", s_axi_arready, '0);
    chk("limit_pop_rvalid", s_axi_rvalid, 4'b0001);
    @(negedge clk);
    drive(4'b1111, 48'h100, 48'h200, 48'h300, 48'h400, 1'b1, 1'b0, '0, '1);
    #1;
    chk("limit_release_arready", s_axi_arready, 4'b0001);
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(4'b1010, 48'h100, 48'h200, 48'h300, 48'h400, 1'b1, 1'b0, '0, '1);
      #1;
      chk($sformatf("strict_grant%0d", c), s_axi_arready, 4'b0010);
    end
`endif

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(N'($urandom), AW'({$urandom, $urandom}), AW'({$urandom, $urandom}),
            AW'({$urandom, $urandom}), AW'({$urandom, $urandom}),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom,
            {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)});
      #1;
      model_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arb.md
# axi_rd_arb

Round-robin arbiter that shares one narrow, single-beat AXI4 read port among NUM_REQ SpMV requesters (column-index, value and x-vector fetch engines). It sits directly upstream of the burst-aggregating read demux, which returns responses strictly in request order. The block registers the winning AR request and records the grant index in a route FIFO. Each returning R beat is steered back to its originating requester.

## Interface
- NUM_REQ, 4: number of requesters; range 2..16.
- ADDR_WIDTH, 48: AR address width.
- DATA_WIDTH, 32: R data width.
- MAX_OUTSTANDING, 16: route FIFO depth, i.e. the in-flight AR limit; power of two.
- IDX_W (localparam): clog2(NUM_REQ).

Ports:
- clk  in  1: the single clock.
- rst  in  1: asynchronous, active-high reset.
- s_axi_arvalid  in  NUM_REQ: per-requester AR valid.
- s_axi_araddr  in  NUM_REQ*ADDR_WIDTH: packed addresses; requester k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- s_axi_arready  out  NUM_REQ: one-hot or zero.
- s_axi_rvalid  out  NUM_REQ: one-hot or zero.
- s_axi_rdata  out  DATA_WIDTH: broadcast to all requesters.
- s_axi_rlast  out  NUM_REQ: equals s_axi_rvalid.
- s_axi_rready  in  NUM_REQ: per-requester R ready.
- m_axi_arvalid  out  1: registered.
- m_axi_araddr  out  ADDR_WIDTH: registered.
- m_axi_arlen  out  8: constant 0.
- m_axi_arsize  out  3: constant clog2(DATA_WIDTH/8).
- m_axi_arburst  out  2: constant 2'b01.
- m_axi_arready  in  1
- m_axi_rvalid  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rready  out  1

## Operation
- Output slot:
  - Holds one AR request (m_axi_arvalid, m_axi_araddr).
  - slot_free = ~m_axi_arvalid | m_axi_arready.
- Grant:
  - Computed combinationally over s_axi_arvalid.
  - Round-robin search starts at last_grant+1 and wraps from NUM_REQ-1 to 0.
- Accept condition: s_axi_arready[g] = grant[g] & slot_free & (count < MAX_OUTSTANDING).
- On accept:
  - Slot loads araddr[g] and m_axi_arvalid is set to 1.
  - g is pushed into the route FIFO.
  - last_grant <= g.
- With no accept, m_axi_arvalid is cleared on m_axi_arready.
- last_grant changes only on accept, so a waiting requester never loses its turn.
- R routing:
  - head = FIFO head index.
  - m_axi_rready = ~empty & s_axi_rready[head].
  - s_axi_rvalid[head] = ~empty & m_axi_rvalid; all other bits are 0.
  - m_axi_rready does not depend on m_axi_rvalid. This is mandatory because the downstream rvalid is combinationally gated by rready.
- Pop: occurs on m_axi_rvalid & m_axi_rready.
- count:
  - Increments on push only, decrements on pop only; holds on simultaneous push and pop.
  - Full is evaluated on the registered count only. A same-cycle pop does not free a slot, which keeps the path conservative.
- m_axi_rvalid while the FIFO is empty: m_axi_rready stays 0, no s_axi_rvalid asserts, and the beat is not consumed.

## Timing
- AR latency: requester handshake in cycle t gives m_axi_arvalid=1 at t+1.
- AR throughput: one request per cycle while m_axi_arready=1.
- R path: zero-cycle combinational pass-through.
- Reset values:
  - m_axi_arvalid=0 and m_axi_araddr=0.
  - count=0; the FIFO is empty.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - All s_axi_arready, s_axi_rvalid, s_axi_rlast and m_axi_rready read 0.
- Reset mid-operation clears all state asynchronously and drops in-flight routes. Downstream and requesters are reset together.
- Pointer arithmetic is clog2(MAX_OUTSTANDING) bits wide with natural wrap. count is one bit wider.

## Configuration
- AXI_RD_ARB_STRICT_PRIO_EN defined: fixed priority, lowest index wins, and last_grant is unused. Starvation of high indices is acceptable.
- Undefined (default): round-robin as described above.

## Structure
- Package axi_rd_arb_pkg holds:
  - the clog2 function;
  - the constants AXI_BURST_INCR=2'b01 and AXI_LEN_SINGLE=8'd0.
- Sub-module rr_route_fifo:
  - Width IDX_W, depth MAX_OUTSTANDING.
  - Ports: push, pop, head, count, empty.
  - Register-array storage with asynchronous reset.
- Arbiter logic stays in the top module.

## Test plan
- Single request: requester 2 issues araddr=0x1000 -> m_axi_arvalid at the next cycle with araddr=0x1000. A returned rdata=0xDEADBEEF appears only on s_axi_rvalid[2].
- Fairness: all 4 requesters hold arvalid with m_axi_arready=1 -> grant order 0,1,2,3,0,1.
- Order: requests from 1, 3 and 0; downstream returns 0xA, 0xB, 0xC -> delivered to 1, 3 and 0 respectively.
- Back-pressure:
  - Hold m_axi_arready=0 -> the slot holds its address and all arready stay 0 after the first accept.
  - Release -> the next accept in the same cycle.
- Outstanding limit: 16 accepts with no R -> arready stays 0. One R pop -> arready returns the following cycle.
- Stalled head and reset: s_axi_rready[head]=0 -> m_axi_rready=0 and the beat is held. Assert rst mid-flight -> count=0 and m_axi_arvalid=0 immediately.
- Strict priority (with the macro): requesters 1 and 3 both valid -> 1 wins repeatedly.
